// File: rtl/byte_word_packer.sv
// byte_word_packer
//   Packs a byte stream into 32-bit little-endian words. Bytes arrive one per
//   cycle on a valid/ready port; the first byte of a word lands in [7:0].
//   A flush pulse closes a partial word early and zero-fills the upper lanes.
//   There are two storage stages: an accumulator being filled and an output
//   register being presented. When the output register is still occupied at
//   close time, the accumulator freezes (HOLD) until the output register
//   frees up.
//
// Ports
//   wb_clk_i      clock, all logic on the rising edge
//   wb_rst_i      synchronous active-high reset
//   byte_valid_i  byte_i carries a byte this cycle
//   byte_i        input byte
//   byte_ready_o  packer accepts a byte this cycle
//   flush_i       close the current partial word (single-cycle pulse)
//   word_valid_o  word_o / word_bytes_o are valid
//   word_o        packed word, first byte in [7:0]
//   word_bytes_o  number of valid bytes in word_o (1..4)
//   word_ready_i  consumer takes the word this cycle
//   byte_sel_o    lane the next accepted byte will fill
//   drop_cnt_o    saturating count of bytes offered while not ready

module byte_word_packer #(
  parameter int DROP_W = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_i,
  output logic              byte_ready_o,
  input  logic              flush_i,
  output logic              word_valid_o,
  output logic [31:0]       word_o,
  output logic [2:0]        word_bytes_o,
  input  logic              word_ready_i,
  output logic [1:0]        byte_sel_o,
  output logic [DROP_W-1:0] drop_cnt_o
);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         acc_q, acc_d;
  logic [1:0]          idx_q, idx_d;
  logic [2:0]          hold_bytes_q, hold_bytes_d;
  logic [31:0]         word_q, word_d;
  logic [2:0]          word_bytes_q, word_bytes_d;
  logic                word_valid_q, word_valid_d;
  logic [DROP_W-1:0]   drop_cnt_q, drop_cnt_d;

  logic                byte_ready;
  logic                accept;
  logic                drain;
  logic                out_free;
  logic                close;
  logic [2:0]          fill_cnt;
  logic [31:0]         merged;
  logic [31:0]         closed;

  // Handshake terms plus the "closed" view of the accumulator: the current
  // byte (if any) merged into its lane, and every lane at or above the final
  // byte count forced to zero so a flushed word never carries stale data.
  always_comb begin
    byte_ready = !wb_rst_i && (state_q == FILL);
    accept     = byte_valid_i && byte_ready;
    drain      = word_valid_q && word_ready_i;
    out_free   = !word_valid_q || drain;

    merged = acc_q;
    if (accept) begin
      merged[8*idx_q +: 8] = byte_i;
    end

    fill_cnt = {1'b0, idx_q} + {2'b00, accept};

    // A byte arriving with the flush is counted first; a flush with nothing
    // collected is a no-op so no empty word is ever produced.
    close = (state_q == FILL) &&
            ((accept && (idx_q == 2'd3)) || (flush_i && (fill_cnt != 3'd0)));

    closed = '0;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < fill_cnt) begin
        closed[8*i +: 8] = merged[8*i +: 8];
      end
    end
  end

  // Next-state logic. The output register is reloaded either directly from a
  // closing accumulator or from a held word, and a drain in the same cycle as
  // a reload keeps word_valid high so back-to-back words have no bubble.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    idx_d        = idx_q;
    hold_bytes_d = hold_bytes_q;
    word_d       = word_q;
    word_bytes_d = word_bytes_q;
    word_valid_d = word_valid_q;
    drop_cnt_d   = drop_cnt_q;

    if (drain) begin
      word_valid_d = 1'b0;
    end

    unique case (state_q)
      FILL: begin
        if (close) begin
          idx_d = 2'd0;
          if (out_free) begin
            word_d       = closed;
            word_bytes_d = fill_cnt;
            word_valid_d = 1'b1;
            acc_d        = '0;
          end else begin
            acc_d        = closed;
            hold_bytes_d = fill_cnt;
            state_d      = HOLD;
          end
        end else if (accept) begin
          acc_d = merged;
          idx_d = idx_q + 2'd1;
        end
      end
      HOLD: begin
        if (out_free) begin
          word_d       = acc_q;
          word_bytes_d = hold_bytes_q;
          word_valid_d = 1'b1;
          acc_d        = '0;
          state_d      = FILL;
        end
      end
      default: state_d = FILL;
    endcase

    // Dropped-byte counter sticks at all-ones instead of wrapping.
    if (byte_valid_i && !byte_ready && !wb_rst_i && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + DROP_W'(1);
    end
  end

  // State register; reset discards any partial or held word silently.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= FILL;
      acc_q        <= '0;
      idx_q        <= '0;
      hold_bytes_q <= '0;
      word_q       <= '0;
      word_bytes_q <= '0;
      word_valid_q <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      idx_q        <= idx_d;
      hold_bytes_q <= hold_bytes_d;
      word_q       <= word_d;
      word_bytes_q <= word_bytes_d;
      word_valid_q <= word_valid_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign byte_ready_o = byte_ready;
  assign word_valid_o = word_valid_q;
  assign word_o       = word_q;
  assign word_bytes_o = word_bytes_q;
  assign byte_sel_o   = idx_q;
  assign drop_cnt_o   = drop_cnt_q;

endmodule

// File: tb/tb_byte_word_packer.sv
// tb_byte_word_packer
//   Directed bench for byte_word_packer. Expected words are queued as the
//   stimulus that closes them is driven; a negedge monitor pops and compares
//   every word the DUT hands over (valid & ready). Point checks cover reset,
//   stalls, flush corner cases and counter saturation.

module tb_byte_word_packer;

  logic        wb_clk_i;
  logic        wb_rst_i;
  logic        byte_valid_i;
  logic [7:0]  byte_i;
  logic        byte_ready_o;
  logic        flush_i;
  logic        word_valid_o;
  logic [31:0] word_o;
  logic [2:0]  word_bytes_o;
  logic        word_ready_i;
  logic [1:0]  byte_sel_o;
  logic [7:0]  drop_cnt_o;

  typedef struct {
    logic [31:0] word;
    logic [2:0]  bytes;
  } exp_t;

  exp_t expQ[$];
  int   nAssert = 0;
  int   nFail   = 0;

  byte_word_packer #(.DROP_W(8)) dut (
    .wb_clk_i     (wb_clk_i),
    .wb_rst_i     (wb_rst_i),
    .byte_valid_i (byte_valid_i),
    .byte_i       (byte_i),
    .byte_ready_o (byte_ready_o),
    .flush_i      (flush_i),
    .word_valid_o (word_valid_o),
    .word_o       (word_o),
    .word_bytes_o (word_bytes_o),
    .word_ready_i (word_ready_i),
    .byte_sel_o   (byte_sel_o),
    .drop_cnt_o   (drop_cnt_o)
  );

  // 10 ns clock
  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  // One compared value: counts, asserts, reports tag/observed/expected.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nAssert++;
    assert (observed === expected)
    else begin
      nFail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, then return 1 ns after the capturing edge.
  task automatic applyStimulus(input logic v, input logic [7:0] b,
                               input logic f, input logic rdy,
                               input logic rst);
    byte_valid_i = v;
    byte_i       = b;
    flush_i      = f;
    word_ready_i = rdy;
    wb_rst_i     = rst;
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic pushWord(input logic [31:0] w, input logic [2:0] n);
    exp_t e;
    e.word  = w;
    e.bytes = n;
    expQ.push_back(e);
  endtask

  // Scoreboard: a handover happens on the next edge whenever valid & ready
  // are both high mid-cycle.
  always @(negedge wb_clk_i) begin
    if (!wb_rst_i && word_valid_o && word_ready_i) begin
      nAssert++;
      assert (expQ.size() > 0)
      else begin
        nFail++;
        $error("[TB] FAIL unexpected_word: observed %h/%0d expected none",
               word_o, word_bytes_o);
      end
      if (expQ.size() > 0) begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("word", word_o, e.word);
        checkOutput("word_bytes", 32'(word_bytes_o), 32'(e.bytes));
      end
    end
  end

  initial begin
    // Reset state, checked while reset is still asserted
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    checkOutput("rst_valid", 32'(word_valid_o), 32'd0);
    checkOutput("rst_word", word_o, 32'd0);
    checkOutput("rst_bytes", 32'(word_bytes_o), 32'd0);
    checkOutput("rst_sel", 32'(byte_sel_o), 32'd0);
    checkOutput("rst_drop", 32'(drop_cnt_o), 32'd0);
    checkOutput("rst_ready", 32'(byte_ready_o), 32'd0);

    // 1: full word with consumer always ready
    $display("[TB] test 1: full word");
    pushWord(32'h44332211, 3'd4);
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b1, 1'b0);
    checkOutput("t1_sel", 32'(byte_sel_o), 32'd1);
    applyStimulus(1'b1, 8'h22, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h33, 1'b0, 1'b1, 1'b0);
    checkOutput("t1_valid_low", 32'(word_valid_o), 32'd0);
    applyStimulus(1'b1, 8'h44, 1'b0, 1'b1, 1'b0);
    checkOutput("t1_valid_rise", 32'(word_valid_o), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    checkOutput("t1_valid_fall", 32'(word_valid_o), 32'd0);

    // 2: consumer stalled, second word held, then back-to-back drain
    $display("[TB] test 2: stall and hold");
    pushWord(32'h04030201, 3'd4);
    pushWord(32'h08070605, 3'd4);
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    end
    checkOutput("t2_ready_hold", 32'(byte_ready_o), 32'd0);
    checkOutput("t2_word_held", word_o, 32'h04030201);
    applyStimulus(1'b1, 8'h09, 1'b0, 1'b0, 1'b0);
    checkOutput("t2_drop", 32'(drop_cnt_o), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    checkOutput("t2_no_bubble", 32'(word_valid_o), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    checkOutput("t2_drained", 32'(word_valid_o), 32'd0);
    checkOutput("t2_ready_back", 32'(byte_ready_o), 32'd1);

    // 3: partial flush, then flush with nothing collected
    $display("[TB] test 3: flush");
    pushWord(32'h0000BBAA, 3'd2);
    applyStimulus(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'hBB, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    checkOutput("t3_flush_valid", 32'(word_valid_o), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    checkOutput("t3_empty_flush", 32'(word_valid_o), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    checkOutput("t3_sel_zero", 32'(byte_sel_o), 32'd0);

    // 4: flush together with the 4th byte is an ordinary full word;
    //    flush together with the 2nd byte includes that byte
    $display("[TB] test 4: flush with byte");
    pushWord(32'h04030201, 3'd4);
    applyStimulus(1'b1, 8'h01, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h02, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h03, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h04, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    pushWord(32'h00000201, 3'd2);
    applyStimulus(1'b1, 8'h01, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h02, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // 5: reset aborts a partial word and clears the drop counter
    $display("[TB] test 5: reset mid-word");
    applyStimulus(1'b1, 8'h01, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h02, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    checkOutput("t5_rst_sel", 32'(byte_sel_o), 32'd0);
    checkOutput("t5_rst_drop", 32'(drop_cnt_o), 32'd0);
    checkOutput("t5_rst_ready", 32'(byte_ready_o), 32'd0);
    checkOutput("t5_rst_valid", 32'(word_valid_o), 32'd0);
    pushWord(32'h08070605, 3'd4);
    for (int i = 5; i <= 8; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0, 1'b1, 1'b0);
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // 6: drop counter saturation
    $display("[TB] test 6: drop saturation");
    pushWord(32'h55555555, 3'd4);
    pushWord(32'h55555555, 3'd4);
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    end
    checkOutput("t6_drop_sat", 32'(drop_cnt_o), 32'hFF);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    end
    checkOutput("t6_drop_nowrap", 32'(drop_cnt_o), 32'hFF);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    checkOutput("words_outstanding", 32'(expQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nAssert, nFail);
    $finish;
  end

endmodule
